// File: rtl/audio_sched_pkg.sv
// Shared types and defaults for the audio read scheduler: FSM state encoding,
// consumer count and default buffer geometry.
package audio_sched_pkg;

    localparam int NCONS      = 2;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        FETCH,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/sched_out_slot.sv
// One-entry valid/ready holding register feeding one consumer of the scheduler.
module sched_out_slot
    import audio_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              btn_s1_resetb,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // The scheduler only loads an empty slot, so load never collides with a transfer.
    always_ff @(posedge clk or negedge btn_s1_resetb) begin
        if (!btn_s1_resetb) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_read_scheduler.sv
// Drains one ping-pong read buffer from RAM into two consumer slots, round-robin.
// Build with SCHED_OVERRUN_CNT_EN defined to get a saturating overrun counter.
//
// state   | meaning
// IDLE    | waiting for buffer_ready_i
// ARB     | pick next eligible consumer, or finish the buffer
// FETCH   | one-cycle RAM read at the granted consumer's pointer
// CAPTURE | load read data into the granted slot, advance its pointer
// DONE    | buffer drained; done pulse follows one cycle later
module audio_read_scheduler
    import audio_sched_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          btn_s1_resetb,
    input  logic                          buffer_ready_i,
    output logic                          buffer_done_o,
    output logic                          rd_en_o,
    output logic [$clog2(DEPTH)-1:0]      rd_addr_o,
    input  logic [DATA_W-1:0]             rd_data_i,
    input  logic [NCONS-1:0]              cons_en_i,
    output logic [NCONS-1:0]              sample_valid_o,
    input  logic [NCONS-1:0]              sample_ready_i,
    output logic [NCONS-1:0][DATA_W-1:0]  sample_data_o,
    output logic                          overrun_o,
    output logic [7:0]                    overrun_cnt_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(DEPTH);

    state_t             state, state_nxt;
    logic [NCONS-1:0]   en_q;
    logic [PTR_W-1:0]   ptr_q [NCONS];
    logic               last_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               done_q;
    logic               overrun_q;
    logic [NCONS-1:0]   slot_valid;
    logic [NCONS-1:0]   slot_load;
    logic [NCONS-1:0]   eligible;
    logic [NCONS-1:0]   finished;
    logic               grant;
    logic               pick;
    logic               ignored;

    assign ignored = buffer_ready_i && (state != IDLE);

    always_comb begin
        state_nxt = state;
        eligible  = '0;
        finished  = '0;
        grant     = 1'b0;
        pick      = last_q;
        for (int i = 0; i < NCONS; i++) begin
            eligible[i] = en_q[i] && (ptr_q[i] < PTR_END) && !slot_valid[i];
            finished[i] = !en_q[i] || ((ptr_q[i] == PTR_END) && !slot_valid[i]);
        end
        case (state)
            IDLE: begin
                if (buffer_ready_i) state_nxt = (cons_en_i == '0) ? DONE : ARB;
            end
            ARB: begin
                if (&finished) begin
                    state_nxt = DONE;
                end else if (|eligible) begin
                    grant     = 1'b1;
                    pick      = (&eligible) ? !last_q : eligible[1];
                    state_nxt = FETCH;
                end
            end
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = ARB;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_q doubles as the current grant from FETCH through CAPTURE.
    always_ff @(posedge clk or negedge btn_s1_resetb) begin
        if (!btn_s1_resetb) begin
            state     <= IDLE;
            en_q      <= '0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NCONS; i++) ptr_q[i] <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == DONE);
            if (ignored) overrun_q <= 1'b1;
            if (state == IDLE && buffer_ready_i) begin
                en_q <= cons_en_i;
                for (int i = 0; i < NCONS; i++) ptr_q[i] <= '0;
            end
            if (grant) begin
                last_q <= pick;
                addr_q <= ptr_q[pick][ADDR_W-1:0];
            end
            if (state == CAPTURE) ptr_q[last_q] <= ptr_q[last_q] + PTR_W'(1);
        end
    end

    for (genvar i = 0; i < NCONS; i++) begin : g_slot
        assign slot_load[i] = (state == CAPTURE) && (last_q == 1'(i));
        sched_out_slot #(.DATA_W(DATA_W)) u_slot (
            .clk           (clk),
            .btn_s1_resetb (btn_s1_resetb),
            .load          (slot_load[i]),
            .load_data     (rd_data_i),
            .ready         (sample_ready_i[i]),
            .valid         (slot_valid[i]),
            .data          (sample_data_o[i])
        );
    end

`ifdef SCHED_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;
    always_ff @(posedge clk or negedge btn_s1_resetb) begin
        if (!btn_s1_resetb)                    ovr_cnt_q <= 8'd0;
        else if (ignored && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
    assign overrun_cnt_o = ovr_cnt_q;
`else
    assign overrun_cnt_o = 8'd0;
`endif

    assign sample_valid_o = slot_valid;
    assign rd_en_o        = (state == FETCH);
    assign rd_addr_o      = addr_q;
    assign buffer_done_o  = done_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_audio_read_scheduler.sv
// Directed plus randomized bench for audio_read_scheduler with a RAM model and
// an in-order per-consumer delivery model.
module tb_audio_read_scheduler;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 24;
`ifdef SCHED_OVERRUN_CNT_EN
    localparam int EXP_OVR = 3;
`else
    localparam int EXP_OVR = 0;
`endif

    logic                        clk = 1'b0;
    logic                        btn_s1_resetb;
    logic                        buffer_ready_i;
    logic                        buffer_done_o;
    logic                        rd_en_o;
    logic [3:0]                  rd_addr_o;
    logic [DATA_W-1:0]           rd_data_i;
    logic [1:0]                  cons_en_i;
    logic [1:0]                  sample_valid_o;
    logic [1:0]                  sample_ready_i;
    logic [1:0][DATA_W-1:0]      sample_data_o;
    logic                        overrun_o;
    logic [7:0]                  overrun_cnt_o;

    audio_read_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .btn_s1_resetb  (btn_s1_resetb),
        .buffer_ready_i (buffer_ready_i),
        .buffer_done_o  (buffer_done_o),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_i      (rd_data_i),
        .cons_en_i      (cons_en_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_data_o  (sample_data_o),
        .overrun_o      (overrun_o),
        .overrun_cnt_o  (overrun_cnt_o)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    int total = 0;
    int bad = 0;
    int exp_idx [2];
    int rd_cnt = 0;
    int done_cnt = 0;
    int order [$];
    bit prev_hold [2];
    bit prev_xfer [2];
    logic [DATA_W-1:0] prev_data [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM: data one cycle after the read strobe.
    always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

    // Delivery model: each consumer must see mem[0..DEPTH-1] in order, with stable hold.
    always @(negedge clk) begin
        if (!btn_s1_resetb) begin
            for (int i = 0; i < 2; i++) begin
                prev_hold[i] = 1'b0;
                prev_xfer[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (prev_hold[i]) begin
                    chk("hold_valid", 32'(sample_valid_o[i]), 32'd1);
                    chk("hold_data", 32'(sample_data_o[i]), 32'(prev_data[i]));
                end
                if (prev_xfer[i]) chk("empty_after_xfer", 32'(sample_valid_o[i]), 32'd0);
                prev_hold[i] = sample_valid_o[i] && !sample_ready_i[i];
                prev_xfer[i] = sample_valid_o[i] && sample_ready_i[i];
                prev_data[i] = sample_data_o[i];
                if (sample_valid_o[i] && sample_ready_i[i]) begin
                    chk("idx_in_range", 32'(exp_idx[i] < DEPTH), 32'd1);
                    if (exp_idx[i] < DEPTH)
                        chk(i == 0 ? "data_c0" : "data_c1", 32'(sample_data_o[i]), 32'(mem[exp_idx[i]]));
                    exp_idx[i]++;
                    order.push_back(i);
                end
            end
            if (rd_en_o) rd_cnt++;
            if (buffer_done_o) done_cnt++;
        end
    end

    task automatic fill_mem(input bit ramp);
        for (int a = 0; a < DEPTH; a++) mem[a] = ramp ? DATA_W'(a) : DATA_W'($urandom);
    endtask

    task automatic start_buf(input logic [1:0] en);
        exp_idx[0] = 0;
        exp_idx[1] = 0;
        rd_cnt = 0;
        order.delete();
        cons_en_i = en;
        buffer_ready_i = 1'b1;
        tick();
        buffer_ready_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            if (rnd) sample_ready_i = 2'($urandom);
            n++;
        end
        chk("done_seen", 32'(done_cnt), 32'(start + 1));
        sample_ready_i = 2'b11;
        repeat (4) tick();
        chk("done_once", 32'(done_cnt), 32'(start + 1));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_done"}, 32'(buffer_done_o), 32'd0);
        chk({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid_o), 32'd0);
        chk({tag, "_data0"}, 32'(sample_data_o[0]), 32'd0);
        chk({tag, "_data1"}, 32'(sample_data_o[1]), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun_o), 32'd0);
        chk({tag, "_ovr_cnt"}, 32'(overrun_cnt_o), 32'd0);
    endtask

    initial begin
        logic [1:0] en;
        int d0;
        int n;
        btn_s1_resetb  = 1'b0;
        buffer_ready_i = 1'b0;
        cons_en_i      = 2'b00;
        sample_ready_i = 2'b11;
        rd_data_i      = '0;
        exp_idx[0] = 0;
        exp_idx[1] = 0;
        fill_mem(1'b1);
        #2;
        chk_zero_outputs("reset");
        tick();
        tick();
        btn_s1_resetb = 1'b1;
        tick();

        // Both consumers, always ready, ramp data: latency and alternation.
        start_buf(2'b11);
        chk("lat_arb_rd_en", 32'(rd_en_o), 32'd0);
        tick();
        chk("lat_fetch_rd_en", 32'(rd_en_o), 32'd1);
        chk("lat_fetch_addr", 32'(rd_addr_o), 32'd0);
        tick();
        chk("lat_capture_rd_en", 32'(rd_en_o), 32'd0);
        chk("lat_capture_valid", 32'(sample_valid_o), 32'd0);
        tick();
        chk("lat_valid", 32'(sample_valid_o), 32'b01);
        chk("lat_data", 32'(sample_data_o[0]), 32'd0);
        wait_done(600, 1'b0);
        chk("s1_cnt_c0", 32'(exp_idx[0]), 32'd16);
        chk("s1_cnt_c1", 32'(exp_idx[1]), 32'd16);
        chk("s1_rd_cnt", 32'(rd_cnt), 32'd32);
        chk("s1_order_len", 32'(order.size()), 32'd32);
        for (int k = 0; k < order.size(); k++) chk("s1_grant_alt", 32'(order[k]), 32'(k % 2));
        chk("s1_no_overrun", 32'(overrun_o), 32'd0);

        // Consumer 1 stalled must not block consumer 0.
        fill_mem(1'b0);
        sample_ready_i = 2'b01;
        d0 = done_cnt;
        start_buf(2'b11);
        n = 0;
        while (exp_idx[0] < DEPTH && n < 600) begin tick(); n++; end
        repeat (10) tick();
        chk("s2_cnt_c0", 32'(exp_idx[0]), 32'd16);
        chk("s2_cnt_c1", 32'(exp_idx[1]), 32'd0);
        chk("s2_c1_valid", 32'(sample_valid_o[1]), 32'd1);
        chk("s2_c1_data", 32'(sample_data_o[1]), 32'(mem[0]));
        chk("s2_no_done", 32'(done_cnt), 32'(d0));
        sample_ready_i = 2'b11;
        wait_done(600, 1'b0);
        chk("s2_cnt_c1_final", 32'(exp_idx[1]), 32'd16);

        // Only consumer 0 enabled.
        fill_mem(1'b0);
        start_buf(2'b01);
        wait_done(600, 1'b0);
        chk("s3_cnt_c0", 32'(exp_idx[0]), 32'd16);
        chk("s3_cnt_c1", 32'(exp_idx[1]), 32'd0);
        chk("s3_rd_cnt", 32'(rd_cnt), 32'd16);

        // Nothing enabled: done two cycles after buffer_ready_i, no reads.
        start_buf(2'b00);
        chk("s4_done_early", 32'(buffer_done_o), 32'd0);
        tick();
        chk("s4_done_pulse", 32'(buffer_done_o), 32'd1);
        tick();
        chk("s4_done_end", 32'(buffer_done_o), 32'd0);
        chk("s4_rd_cnt", 32'(rd_cnt), 32'd0);

        // Three buffer_ready_i pulses while busy.
        fill_mem(1'b0);
        start_buf(2'b11);
        repeat (3) tick();
        repeat (3) begin
            buffer_ready_i = 1'b1;
            tick();
            buffer_ready_i = 1'b0;
            tick();
        end
        chk("s5_overrun", 32'(overrun_o), 32'd1);
        chk("s5_overrun_cnt", 32'(overrun_cnt_o), 32'(EXP_OVR));
        wait_done(600, 1'b0);
        chk("s5_cnt_c0", 32'(exp_idx[0]), 32'd16);
        chk("s5_cnt_c1", 32'(exp_idx[1]), 32'd16);

        // Reset after sample 5 of consumer 0, then a clean restart.
        fill_mem(1'b0);
        start_buf(2'b11);
        n = 0;
        while (exp_idx[0] < 6 && n < 300) begin tick(); n++; end
        chk("s6_reached_6", 32'(exp_idx[0]), 32'd6);
        d0 = done_cnt;
        btn_s1_resetb = 1'b0;
        #1;
        chk_zero_outputs("s6_rst");
        tick();
        tick();
        btn_s1_resetb = 1'b1;
        repeat (3) tick();
        chk("s6_no_done", 32'(done_cnt), 32'(d0));
        fill_mem(1'b0);
        start_buf(2'b11);
        wait_done(600, 1'b0);
        chk("s6_cnt_c0", 32'(exp_idx[0]), 32'd16);
        chk("s6_cnt_c1", 32'(exp_idx[1]), 32'd16);

        // Random enables and random ready back-pressure.
        for (int it = 0; it < 5; it++) begin
            en = 2'($urandom_range(0, 3));
            fill_mem(1'b0);
            start_buf(en);
            wait_done(2000, 1'b1);
            chk("rnd_cnt_c0", 32'(exp_idx[0]), en[0] ? 32'd16 : 32'd0);
            chk("rnd_cnt_c1", 32'(exp_idx[1]), en[1] ? 32'd16 : 32'd0);
            chk("rnd_rd_cnt", 32'(rd_cnt), 32'(16 * (int'(en[0]) + int'(en[1]))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
